// File: rtl/mem_axi_master_if_if.sv
// ---------------------------------------------------------------------------
// AXI_BUS : AXI4 bus bundle used by mem_axi_master_if.
//   Parameters : AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH
//   Channels   : AW, W, B, AR, R with valid/ready handshakes
//   Modports   : Master (drives AW/W/AR payloads, B/R ready)
//                Slave  (mirror image)
// ---------------------------------------------------------------------------
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 16,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem_axi_master_if.sv
// ---------------------------------------------------------------------------
// mem_axi_master_if : bridge from a 64-bit single-word memory request port to
// an AXI4 master. One transaction outstanding, every transaction one beat.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   mem_csn_i          request (active-low)
//   mem_wen_i          0 = write, 1 = read
//   mem_add_i          64-bit word address
//   mem_wdata_i        write data
//   mem_be_i           byte enables
//   mem_gnt_o          request accepted this cycle
//   mem_rvalid_o       one-cycle completion pulse (reads and writes)
//   mem_rdata_o        read data, holds between read completions
//   mem_err_o          response error (only with MEM_AXI_MASTER_ERR_EN)
//   axi_master         AXI4 master port
//
// Optional feature: define MEM_AXI_MASTER_ERR_EN to add mem_err_o, which
// reports bit 1 of the B/R response (SLVERR or DECERR).
// ---------------------------------------------------------------------------
module mem_axi_master_if #(
    parameter int unsigned AXI_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH    = 64,
    parameter int unsigned AXI_ID_WIDTH      = 16,
    parameter int unsigned AXI_USER_WIDTH    = 10,
    parameter int unsigned AXI_ID            = 0,
    parameter int unsigned MEM_ADDR_WIDTH    = 29
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mem_csn_i,
    input  logic                      mem_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_add_i,
    input  logic [63:0]               mem_wdata_i,
    input  logic [7:0]                mem_be_i,
    output logic                      mem_gnt_o,
    output logic                      mem_rvalid_o,
    output logic [63:0]               mem_rdata_o,
`ifdef MEM_AXI_MASTER_ERR_EN
    output logic                      mem_err_o,
`endif
    AXI_BUS.Master                    axi_master
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

    state_e                      state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]                  be_q, be_d;
`ifdef MEM_AXI_MASTER_ERR_EN
    logic                        err_q, err_d;
`endif

    logic gnt, aw_valid, w_valid, b_ready, ar_valid, r_ready;

    // Response side-band fields and r_last carry nothing for single beats.
    logic unused_sigs;
    assign unused_sigs = ^{axi_master.b_id, axi_master.b_user, axi_master.b_resp,
                           axi_master.r_id, axi_master.r_user, axi_master.r_resp,
                           axi_master.r_last};

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
`ifdef MEM_AXI_MASTER_ERR_EN
        err_d     = err_q;
`endif
        gnt       = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt = rst_ni & ~mem_csn_i;
                if (gnt) begin
                    addr_d  = mem_add_i;
                    wdata_d = mem_wdata_i;
                    be_d    = mem_be_i;
                    state_d = mem_wen_i ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; each valid drops after its own handshake.
                aw_valid  = ~aw_done_q;
                w_valid   = ~w_done_q;
                aw_done_d = aw_done_q | axi_master.aw_ready;
                w_done_d  = w_done_q  | axi_master.w_ready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (axi_master.b_valid) begin
                    rvalid_d = 1'b1;
`ifdef MEM_AXI_MASTER_ERR_EN
                    err_d    = axi_master.b_resp[1];
`endif
                    state_d  = IDLE;
                end
            end
            RD_REQ: begin
                ar_valid = 1'b1;
                if (axi_master.ar_ready) state_d = RD_RESP;
            end
            RD_RESP: begin
                r_ready = 1'b1;
                if (axi_master.r_valid) begin
                    rdata_d  = axi_master.r_data;
                    rvalid_d = 1'b1;
`ifdef MEM_AXI_MASTER_ERR_EN
                    err_d    = axi_master.r_resp[1];
`endif
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
`ifdef MEM_AXI_MASTER_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
`ifdef MEM_AXI_MASTER_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Request payload is only consumed after a grant, so it needs no reset.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    assign mem_gnt_o    = gnt;
    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
`ifdef MEM_AXI_MASTER_ERR_EN
    assign mem_err_o    = err_q;
`endif

    assign axi_master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master.aw_addr   = AXI_ADDRESS_WIDTH'({addr_q, 3'b000});
    assign axi_master.aw_len    = 8'd0;
    assign axi_master.aw_size   = 3'd3;
    assign axi_master.aw_burst  = 2'b01;
    assign axi_master.aw_lock   = 1'b0;
    assign axi_master.aw_cache  = 4'd0;
    assign axi_master.aw_prot   = 3'd0;
    assign axi_master.aw_qos    = 4'd0;
    assign axi_master.aw_region = 4'd0;
    assign axi_master.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_master.aw_valid  = aw_valid;

    assign axi_master.w_data    = wdata_q;
    assign axi_master.w_strb    = be_q;
    assign axi_master.w_last    = 1'b1;
    assign axi_master.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign axi_master.w_valid   = w_valid;

    assign axi_master.b_ready   = b_ready;

    assign axi_master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master.ar_addr   = AXI_ADDRESS_WIDTH'({addr_q, 3'b000});
    assign axi_master.ar_len    = 8'd0;
    assign axi_master.ar_size   = 3'd3;
    assign axi_master.ar_burst  = 2'b01;
    assign axi_master.ar_lock   = 1'b0;
    assign axi_master.ar_cache  = 4'd0;
    assign axi_master.ar_prot   = 3'd0;
    assign axi_master.ar_qos    = 4'd0;
    assign axi_master.ar_region = 4'd0;
    assign axi_master.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_master.ar_valid  = ar_valid;

    assign axi_master.r_ready   = r_ready;

endmodule

// File: tb/tb_mem_axi_master_if.sv
module tb_mem_axi_master_if;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        csn;
    logic        wen;
    logic [28:0] add;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
`ifdef MEM_AXI_MASTER_ERR_EN
    logic        err;
`endif

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
              .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)) axi ();

    mem_axi_master_if #(
        .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(16),
        .AXI_USER_WIDTH(10), .AXI_ID(0), .MEM_ADDR_WIDTH(29)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_csn_i   (csn),
        .mem_wen_i   (wen),
        .mem_add_i   (add),
        .mem_wdata_i (wdata),
        .mem_be_i    (be),
        .mem_gnt_o   (gnt),
        .mem_rvalid_o(rvalid),
        .mem_rdata_o (rdata),
`ifdef MEM_AXI_MASTER_ERR_EN
        .mem_err_o   (err),
`endif
        .axi_master  (axi)
    );

    // ---------------- slave configuration (written by the stimulus) -------
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [63:0] s_rdata;
    logic [1:0]  s_resp;

    // ---------------- slave state and captured payloads --------------------
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0;
    bit          aw_seen, w_seen, ar_seen, b_fire, r_fire;
    logic [31:0] cap_aw_addr, cap_ar_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_wlast;
    logic [28:0] cap_aw_fix, cap_ar_fix;

    localparam logic [28:0] FIX_EXP = {8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};

    // Slave decides its readies at the falling edge; a handshake happens at
    // the next rising edge when the DUT valid seen here is high.
    always @(negedge clk) begin
        if (!rst_n) begin
            axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
            axi.b_valid = 1'b0;  axi.r_valid = 1'b0;
            axi.b_resp = 2'b00;  axi.r_resp = 2'b00; axi.r_data = '0;
            axi.b_id = '0; axi.b_user = '0; axi.r_id = '0; axi.r_user = '0;
            axi.r_last = 1'b0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin axi.b_valid = 1'b0; aw_seen = 0; w_seen = 0; b_cnt = 0; end
            if (r_fire) begin axi.r_valid = 1'b0; ar_seen = 0; r_cnt = 0; end
            if (aw_seen && w_seen && !axi.b_valid) begin
                if (b_cnt >= b_dly) begin axi.b_valid = 1'b1; axi.b_resp = s_resp; end
                else b_cnt++;
            end
            if (ar_seen && !axi.r_valid) begin
                if (r_cnt >= r_dly) begin
                    axi.r_valid = 1'b1; axi.r_data = s_rdata;
                    axi.r_resp = s_resp; axi.r_last = 1'b1;
                end else r_cnt++;
            end
            b_fire = axi.b_valid && axi.b_ready;
            r_fire = axi.r_valid && axi.r_ready;

            axi.aw_ready = 1'b0;
            if (axi.aw_valid) begin
                aw_hi++;
                if (aw_cnt >= aw_dly) begin
                    axi.aw_ready = 1'b1; aw_seen = 1; aw_cnt = 0;
                    cap_aw_addr = axi.aw_addr;
                    cap_aw_fix = {axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock,
                                  axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region};
                end else aw_cnt++;
            end else aw_cnt = 0;

            axi.w_ready = 1'b0;
            if (axi.w_valid) begin
                w_hi++;
                if (w_cnt >= w_dly) begin
                    axi.w_ready = 1'b1; w_seen = 1; w_cnt = 0;
                    cap_wdata = axi.w_data; cap_wstrb = axi.w_strb; cap_wlast = axi.w_last;
                end else w_cnt++;
            end else w_cnt = 0;

            axi.ar_ready = 1'b0;
            if (axi.ar_valid) begin
                ar_hi++;
                if (ar_cnt >= ar_dly) begin
                    axi.ar_ready = 1'b1; ar_seen = 1; ar_cnt = 0;
                    cap_ar_addr = axi.ar_addr;
                    cap_ar_fix = {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock,
                                  axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region};
                end else ar_cnt++;
            end else ar_cnt = 0;
        end
    end

    // ---------------- checking ---------------------------------------------
    int total = 0;
    int bad   = 0;
    logic [63:0] last_rd;   // model: value mem_rdata_o must hold

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wen;
        logic [28:0] add;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          exp_lat;
    } vec_t;

    // Latency from grant to completion, from the per-channel wait states.
    function automatic int model_latency(input vec_t v);
        if (v.wen) return 3 + v.ar_dly + v.r_dly;
        return 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
    endfunction

    function automatic logic [31:0] model_addr(input logic [28:0] a);
        return 32'({3'b000, a}) * 32'd8;
    endfunction

    task automatic set_slave(input vec_t v);
        aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
        ar_dly = v.ar_dly; r_dly = v.r_dly;
        s_rdata = v.rdata; s_resp = v.resp;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        int aw0, w0, ar0;
        set_slave(v);
        aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi;
        @(negedge clk);
        csn = 1'b0; wen = v.wen; add = v.add; wdata = v.wdata; be = v.be;
        #1;
        lat = 0;
        while (!gnt && lat < 50) begin @(negedge clk); #1; lat++; end
        check({tag, "_gnt"}, gnt, 1);
        @(negedge clk);
        csn = 1'b1; wen = $urandom_range(0, 1); add = $urandom;
        #1;
        lat = 1;
        while (!rvalid && lat < 300) begin @(negedge clk); #1; lat++; end
        check({tag, "_latency"}, lat, v.exp_lat);
        if (v.wen) begin
            last_rd = v.rdata;
            check({tag, "_rdata"}, rdata, last_rd);
            check({tag, "_ar_addr"}, cap_ar_addr, model_addr(v.add));
            check({tag, "_ar_fixed"}, cap_ar_fix, FIX_EXP);
            check({tag, "_ar_cycles"}, ar_hi - ar0, v.ar_dly + 1);
        end else begin
            check({tag, "_rdata_kept"}, rdata, last_rd);
            check({tag, "_aw_addr"}, cap_aw_addr, model_addr(v.add));
            check({tag, "_wdata"}, cap_wdata, v.wdata);
            check({tag, "_wstrb"}, cap_wstrb, v.be);
            check({tag, "_wlast"}, cap_wlast, 1);
            check({tag, "_aw_fixed"}, cap_aw_fix, FIX_EXP);
            check({tag, "_aw_cycles"}, aw_hi - aw0, v.aw_dly + 1);
            check({tag, "_w_cycles"}, w_hi - w0, v.w_dly + 1);
        end
`ifdef MEM_AXI_MASTER_ERR_EN
        check({tag, "_err"}, err, v.resp[1]);
`endif
        @(negedge clk); #1;
        check({tag, "_rvalid_pulse"}, rvalid, 0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        int lat;
        int aw0, ar0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int aw0, ar0;
        vec_t wv, rdv;
        // wen add wdata be | aw w b ar r | rdata resp | latency
        tbl[0] = '{1'b1, 29'h100, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 64'hDEADBEEF_CAFEF00D, 2'b00, 3};
        tbl[1] = '{1'b0, 29'h040, 64'h11223344_55667788, 8'h0F, 2, 0, 0, 0, 0, 64'h0, 2'b00, 5};
        tbl[2] = '{1'b0, 29'h0ABCD, 64'hA5A5_0000_FFFF_5A5A, 8'hC3, 0, 3, 1, 0, 0, 64'h0, 2'b00, 7};
        tbl[3] = '{1'b1, 29'h12345, 64'h0, 8'hFF, 0, 0, 0, 2, 4, 64'h0123_4567_89AB_CDEF, 2'b00, 9};
        tbl[4] = '{1'b0, 29'h1FFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 1, 0, 0, 0, 64'h0, 2'b00, 4};
        tbl[5] = '{1'b1, 29'h200, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 64'hBAD0_BAD0_BAD0_BAD0, 2'b10, 3};
        tbl[6] = '{1'b1, 29'h208, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 64'h600D_600D_600D_600D, 2'b00, 3};

        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        s_rdata = '0; s_resp = 2'b00;
        rst_n = 1'b0; csn = 1'b0; wen = 1'b1; add = '0; wdata = '0; be = '0;
        last_rd = '0;

        // Reset state, with a request pending during reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 0);
        check("rst_readies", {axi.b_ready, axi.r_ready}, 0);
        csn = 1'b1; rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back with B backpressure: second request held from cycle 1
        wv  = '{1'b0, 29'h300, 64'hCAFE_0000_0000_BEEF, 8'hAA, 0, 0, 10, 0, 0, 64'h0, 2'b00, 13};
        rdv = '{1'b1, 29'h308, 64'h0, 8'hFF, 0, 0, 10, 0, 0, 64'h7777_1111_2222_3333, 2'b00, 3};
        set_slave(rdv);
        aw0 = aw_hi; ar0 = ar_hi;
        @(negedge clk);
        csn = 1'b0; wen = 1'b0; add = wv.add; wdata = wv.wdata; be = wv.be;
        #1;
        check("b2b_first_gnt", gnt, 1);
        @(negedge clk);
        wen = 1'b1; add = rdv.add;
        #1;
        lat = 1;
        while (!rvalid && lat < 40) begin
            check("bp_gnt_low", gnt, 0);
            if (lat >= 2) check("bp_b_ready", axi.b_ready, 1);
            @(negedge clk); #1; lat++;
        end
        check("b2b_write_latency", lat, wv.exp_lat);
        check("b2b_gnt_with_rvalid", gnt, 1);
        check("b2b_wdata", cap_wdata, wv.wdata);
        @(negedge clk);
        csn = 1'b1;
        #1;
        lat = 1;
        while (!rvalid && lat < 40) begin @(negedge clk); #1; lat++; end
        check("b2b_read_latency", lat, rdv.exp_lat);
        check("b2b_read_data", rdata, rdv.rdata);
        check("b2b_read_addr", cap_ar_addr, model_addr(rdv.add));
        last_rd = rdv.rdata;
        repeat (3) @(negedge clk);
        #1;
        check("b2b_single_aw", aw_hi - aw0, 1);
        check("b2b_single_ar", ar_hi - ar0, 1);
        check("b2b_no_extra_rvalid", rvalid, 0);

        // Synchronous reset while ar_valid is asserted
        rv = '{1'b1, 29'h400, 64'h0, 8'hFF, 0, 0, 0, 20, 0, 64'h5555_AAAA_5555_AAAA, 2'b00, 23};
        set_slave(rv);
        @(negedge clk);
        csn = 1'b0; wen = 1'b1; add = rv.add;
        #1;
        check("rstmid_gnt", gnt, 1);
        @(negedge clk); csn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rstmid_ar_valid_pre", axi.ar_valid, 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rstmid_ar_valid", axi.ar_valid, 0);
        check("rstmid_rvalid", rvalid, 0);
        check("rstmid_rdata", rdata, 0);
        last_rd = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        rv.ar_dly = 1; rv.r_dly = 1; rv.exp_lat = 5;
        run_txn(rv, "post_rst");

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rv.wen    = 1'($urandom_range(0, 1));
            rv.add    = 29'($urandom);
            rv.wdata  = {$urandom, $urandom};
            rv.be     = 8'($urandom);
            rv.aw_dly = $urandom_range(0, 3);
            rv.w_dly  = $urandom_range(0, 3);
            rv.b_dly  = $urandom_range(0, 3);
            rv.ar_dly = $urandom_range(0, 3);
            rv.r_dly  = $urandom_range(0, 3);
            rv.rdata  = {$urandom, $urandom};
            rv.resp   = 2'($urandom);
            rv.exp_lat = model_latency(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
